// File: rtl/gradient_axis_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// gradient_axis_pkg : FSM states and FIFO word layout shared by m_axis_frame_tx
// Revision: 1.0
// ----------------------------------------------------------------------------
package gradient_axis_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        RESYNC = 2'd2
    } tx_state_t;

    // FIFO word is {tuser, tlast, data}; sideband offsets are relative to DATA_WIDTH.
    localparam int SIDEBAND_W = 2;
    localparam int TUSER_OFS  = 1;
    localparam int TLAST_OFS  = 0;

    function automatic int word_width(input int data_w);
        return data_w + SIDEBAND_W;
    endfunction

endpackage

`default_nettype wire

// File: rtl/axis_sync_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// axis_sync_fifo : synchronous FIFO with a registered AXI-Stream read stage
// Revision: 1.0
// ----------------------------------------------------------------------------
module axis_sync_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] rd_data,
    input  logic             rd_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 2);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    mem_count;
    logic [CW-1:0]    total;
    logic             out_valid;
    logic             pop_out;
    logic             load_out;
    logic             wr_ok;

    // Occupancy counts the output register too, so "full" reflects every held beat;
    // the storage keeps one spare slot beyond that threshold.
    assign total    = mem_count + CW'(out_valid);
    assign full     = (total >= CW'(DEPTH));
    assign empty    = !out_valid;
    assign pop_out  = out_valid && rd_ready;
    assign load_out = (!out_valid || pop_out) && (mem_count != '0);
    assign wr_ok    = wr_en && ((mem_count != CW'(DEPTH)) || load_out);

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            mem_count <= '0;
            out_valid <= 1'b0;
            rd_data   <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (load_out) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_ok, load_out})
                2'b10:   mem_count <= mem_count + 1'b1;
                2'b01:   mem_count <= mem_count - 1'b1;
                default: mem_count <= mem_count;
            endcase
            // Data only moves on a load, so it stays stable while stalled.
            if (load_out) begin
                rd_data   <= mem[rd_ptr];
                out_valid <= 1'b1;
            end else if (pop_out) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/m_axis_frame_tx.sv
`default_nettype none
// ----------------------------------------------------------------------------
// m_axis_frame_tx : AXI4-Stream video master with border blanking and SOF resync
// Revision: 1.0
// ----------------------------------------------------------------------------
module m_axis_frame_tx
    import gradient_axis_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    IMG_WIDTH   = 10,
    parameter int                    IMG_HEIGHT  = 10,
    parameter int                    BORDER_TOP  = 4,
    parameter int                    BORDER_LEFT = 4,
    parameter logic [DATA_WIDTH-1:0] BLANK_VALUE = '0,
    parameter int                    FIFO_DEPTH  = 16
) (
    input  logic                  i_clk,
    input  logic                  i_areset,
    input  logic [DATA_WIDTH-1:0] i_pixel,
    input  logic                  i_pixel_valid,
    input  logic                  i_start_of_frame,
    output logic                  o_pixel_ready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tuser,
    output logic                  m_axis_tlast,
    output logic                  o_frame_error,
    output logic                  o_frame_done
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam int WW = word_width(DATA_WIDTH);

    localparam logic [CW-1:0] LAST_COL = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] LAST_ROW = RW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] LEFT_END = CW'(BORDER_LEFT);
    localparam logic [RW-1:0] TOP_END  = RW'(BORDER_TOP);

    tx_state_t       state;
    logic [CW-1:0]   col;
    logic [RW-1:0]   row;
    logic [CW-1:0]   pos_col;
    logic [RW-1:0]   pos_row;
    logic            accept;
    logic            wr_en;
    logic            mid_frame_sof;
    logic            at_last;
    logic            blank;
    logic            wr_tuser;
    logic            wr_tlast;
    logic [DATA_WIDTH-1:0] wr_pixel;
    logic [WW-1:0]   wr_word;
    logic [WW-1:0]   rd_word;
    logic            fifo_full;
    logic            fifo_empty;

    assign o_pixel_ready = !i_areset && ((state == IDLE) || !fifo_full);
    assign accept        = i_pixel_valid && o_pixel_ready;

    // Any accepted SOF is placed at (0,0), whichever state it lands in.
    assign pos_col = i_start_of_frame ? '0 : col;
    assign pos_row = i_start_of_frame ? '0 : row;

    assign wr_en         = accept && ((state != IDLE) || i_start_of_frame);
    assign mid_frame_sof = accept && i_start_of_frame && (state != IDLE)
                           && ((col != '0) || (row != '0));
    assign at_last       = (pos_col == LAST_COL) && (pos_row == LAST_ROW);

    assign blank    = (pos_row < TOP_END) || (pos_col < LEFT_END);
    assign wr_tuser = (pos_col == '0) && (pos_row == '0);
    assign wr_tlast = (pos_col == LAST_COL);
    assign wr_pixel = blank ? BLANK_VALUE : i_pixel;
    assign wr_word  = {wr_tuser, wr_tlast, wr_pixel};

    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            state         <= IDLE;
            col           <= '0;
            row           <= '0;
            o_frame_error <= 1'b0;
            o_frame_done  <= 1'b0;
        end else begin
            o_frame_error <= mid_frame_sof;
            o_frame_done  <= wr_en && at_last;

            if (wr_en) begin
                if (at_last) begin
                    col <= '0;
                    row <= '0;
                end else if (pos_col == LAST_COL) begin
                    col <= '0;
                    row <= pos_row + 1'b1;
                end else begin
                    col <= pos_col + 1'b1;
                    row <= pos_row;
                end
            end

            case (state)
                IDLE: begin
                    if (wr_en) begin
                        state <= at_last ? IDLE : ACTIVE;
                    end
                end
                ACTIVE, RESYNC: begin
                    if (wr_en && at_last) begin
                        state <= IDLE;
                    end else if (mid_frame_sof) begin
                        state <= RESYNC;
                    end else begin
                        state <= ACTIVE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    axis_sync_fifo #(
        .WIDTH (WW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (i_clk),
        .rst      (i_areset),
        .wr_en    (wr_en),
        .wr_data  (wr_word),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .rd_data  (rd_word),
        .rd_ready (m_axis_tready)
    );

    assign m_axis_tvalid = !fifo_empty;
    assign m_axis_tdata  = rd_word[DATA_WIDTH-1:0];
    assign m_axis_tuser  = rd_word[DATA_WIDTH + TUSER_OFS];
    assign m_axis_tlast  = rd_word[DATA_WIDTH + TLAST_OFS];

endmodule

`default_nettype wire

// File: tb/tb_m_axis_frame_tx.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_m_axis_frame_tx : random/directed frames against a linear-index frame model
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_m_axis_frame_tx;

    localparam int DW    = 8;
    localparam int W     = 4;
    localparam int H     = 3;
    localparam int BT    = 1;
    localparam int BL    = 1;
    localparam int DEPTH = 4;
    localparam logic [DW-1:0] BLANK = '0;

    logic          clk = 1'b0;
    logic          areset = 1'b1;
    logic [DW-1:0] pixel = '0;
    logic          pixel_valid = 1'b0;
    logic          sof = 1'b0;
    logic          pixel_ready;
    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tready = 1'b0;
    logic          tuser;
    logic          tlast;
    logic          frame_error;
    logic          frame_done;

    always #5 clk = ~clk;

    m_axis_frame_tx #(
        .DATA_WIDTH  (DW),
        .IMG_WIDTH   (W),
        .IMG_HEIGHT  (H),
        .BORDER_TOP  (BT),
        .BORDER_LEFT (BL),
        .BLANK_VALUE (BLANK),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .i_clk            (clk),
        .i_areset         (areset),
        .i_pixel          (pixel),
        .i_pixel_valid    (pixel_valid),
        .i_start_of_frame (sof),
        .o_pixel_ready    (pixel_ready),
        .m_axis_tdata     (tdata),
        .m_axis_tvalid    (tvalid),
        .m_axis_tready    (tready),
        .m_axis_tuser     (tuser),
        .m_axis_tlast     (tlast),
        .o_frame_error    (frame_error),
        .o_frame_done     (frame_done)
    );

    typedef struct { logic [DW+1:0] word; int wedge; } exp_t;
    typedef struct { logic [DW-1:0] pix; logic sof; } beat_t;

    exp_t  mq[$];
    beat_t src[$];

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int idx = 0;
    bit in_frame = 1'b0;
    bit exp_err = 1'b0;
    bit exp_done = 1'b0;
    int rdy_mode = 0;
    int vprob = 100;
    int stall_lo = 0;
    int stall_hi = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference: frame position is a linear index 0..W*H-1 into the current frame.
    task automatic model_beat(input logic [DW-1:0] pix, input logic s);
        int c;
        int r;
        exp_t e;
        if (s) begin
            if (in_frame && idx != 0) exp_err = 1'b1;
            idx = 0;
            in_frame = 1'b1;
        end
        if (in_frame) begin
            c = idx % W;
            r = idx / W;
            e.word  = {(idx == 0), (c == W - 1), ((r < BT || c < BL) ? BLANK : pix)};
            e.wedge = cyc + 1;
            mq.push_back(e);
            if (idx == W * H - 1) begin
                exp_done = 1'b1;
                in_frame = 1'b0;
                idx = 0;
            end else begin
                idx++;
            end
        end
    endtask

    task automatic step();
        bit exp_v;
        bit acc;
        @(negedge clk);
        cyc++;
        check("frame_error", frame_error, exp_err);
        check("frame_done", frame_done, exp_done);
        check("pixel_ready", pixel_ready, (!in_frame || mq.size() < DEPTH));
        exp_v = (mq.size() > 0) && (mq[0].wedge < cyc);
        check("tvalid", tvalid, exp_v);
        if (exp_v) check("beat", {tuser, tlast, tdata}, mq[0].word);

        case (rdy_mode)
            0:       tready = 1'b1;
            1:       tready = ($urandom_range(0, 1) == 1);
            2:       tready = !(cyc >= stall_lo && cyc < stall_hi);
            default: tready = 1'b0;
        endcase
        if (src.size() > 0) begin
            pixel_valid = ($urandom_range(0, 99) < vprob);
            pixel = src[0].pix;
            sof = src[0].sof;
        end else begin
            pixel_valid = 1'b0;
            pixel = DW'($urandom);
            sof = $urandom_range(0, 1) == 1;
        end
        acc = pixel_valid && pixel_ready;

        exp_err = 1'b0;
        exp_done = 1'b0;
        if (exp_v && tready) void'(mq.pop_front());
        if (acc) begin
            model_beat(src[0].pix, src[0].sof);
            void'(src.pop_front());
        end
    endtask

    task automatic add_beats(input int n, input int first, input bit sof_first);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.pix = DW'(first + i);
            b.sof = sof_first && (i == 0);
            src.push_back(b);
        end
    endtask

    task automatic add_random_frame();
        beat_t b;
        int p;
        bit mid;
        p = $urandom_range(1, W * H - 1);
        mid = ($urandom_range(0, 3) == 0);
        for (int i = 0; i < W * H; i++) begin
            b.pix = DW'($urandom_range(1, 255));
            b.sof = (i == 0) || (mid && i == p);
            src.push_back(b);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((src.size() > 0 || mq.size() > 0) && n < 500) begin
            step();
            n++;
        end
        check("drain_timeout", src.size() + mq.size(), 0);
        step();
        step();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tdata"}, tdata, 0);
        check({tag, "_tvalid"}, tvalid, 0);
        check({tag, "_tuser"}, tuser, 0);
        check({tag, "_tlast"}, tlast, 0);
        check({tag, "_ready"}, pixel_ready, 0);
        check({tag, "_error"}, frame_error, 0);
        check({tag, "_done"}, frame_done, 0);
    endtask

    initial begin
        #1;
        check_reset_outputs("por");
        @(negedge clk);
        @(negedge clk);
        areset = 1'b0;

        // Basic frame
        rdy_mode = 0; vprob = 100;
        add_beats(W * H, 1, 1'b1);
        drain();

        // Pre-SOF garbage dropped
        add_beats(3, 200, 1'b0);
        add_beats(W * H, 1, 1'b1);
        drain();

        // Backpressure window of 10 cycles mid-frame
        rdy_mode = 2; stall_lo = cyc + 4; stall_hi = cyc + 14;
        add_beats(W * H, 1, 1'b1);
        drain();

        // Mid-frame SOF on beat 6
        rdy_mode = 0;
        add_beats(5, 1, 1'b1);
        add_beats(W * H, 50, 1'b1);
        drain();

        // Back-to-back frames
        add_beats(W * H, 1, 1'b1);
        add_beats(W * H, 101, 1'b1);
        drain();

        // Randomized traffic and backpressure
        rdy_mode = 1; vprob = 70;
        for (int f = 0; f < 8; f++) begin
            add_beats($urandom_range(0, 2), 150, 1'b0);
            add_random_frame();
        end
        drain();

        // Reset mid-frame while output is valid
        rdy_mode = 3; vprob = 100;
        add_beats(W * H, 1, 1'b1);
        repeat (6) step();
        check("pre_rst_tvalid", tvalid, 1);
        #2 areset = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        src.delete();
        mq.delete();
        in_frame = 1'b0; idx = 0; exp_err = 1'b0; exp_done = 1'b0;
        pixel_valid = 1'b0;
        @(negedge clk);
        check_reset_outputs("held_rst");
        areset = 1'b0;
        rdy_mode = 0;
        add_beats(W * H, 1, 1'b1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
